div_ratio_ctrl: RTL and testbench
=================================

Name: div_ratio_ctrl

Overview:
- Control stage directly upstream of the odd and even frequency dividers.
- Accepts a requested division ratio N over a valid/ready handshake and range-checks it.
- Classifies N as odd or even and drives the selected divider's P input and path select.
- Issues a one-cycle divider reset, then holds off new requests until the divider output has settled.

Parameters:
- SIZE, 8, width of the ratio and of both P buses; matches the codebase `SIZE.
- DEFAULT_N, 3, ratio loaded at reset; must be odd, >= 3 and <= 2^SIZE-1.
- SETTLE_EXTRA, 2, extra hold-off cycles added after N cycles of settling.

Ports:
- clk  input  1  divider clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- n_in  input  SIZE  requested division ratio N.
- n_valid  input  1  request strobe; a transfer occurs when n_valid && n_ready.
- n_ready  output  1  block can accept a new ratio.
- p_odd  output  SIZE  P for the odd divider.
- p_even  output  SIZE  P for the even divider.
- sel_odd  output  1  1 selects the odd divider output, 0 selects the even one.
- div_reset  output  1  one-cycle reset pulse to both dividers.
- cfg_err  output  1  one-cycle pulse when a rejected ratio is offered.
- busy  output  1  high while in LOAD or SETTLE.

Behaviour:
- Reset values, applied on a clk edge with reset=1:
  - state=IDLE, n_ready=0 for that cycle; n_ready=1 from the next cycle.
  - p_odd=DEFAULT_N, p_even=1, sel_odd=1.
  - div_reset=1 for the reset cycle and 0 afterwards.
  - cfg_err=0, busy=0, settle counter=0.
- Valid ratios: 2 <= N <= 2^SIZE-1. N=0 and N=1 are rejected.
- States:
  - IDLE: n_ready=1. On transfer with valid N: latch N, go to LOAD. On transfer with invalid N: pulse cfg_err next cycle, keep the configuration, stay in IDLE.
  - LOAD (1 cycle):
    - Odd N: p_odd=N, sel_odd=1, p_even unchanged.
    - Even N: p_even=N>>1, sel_odd=0, p_odd unchanged.
    - div_reset=1 and n_ready=0 in this cycle.
    - Load the settle counter with N+SETTLE_EXTRA, computed at SIZE+1 bits with no overflow. Go to SETTLE.
  - SETTLE: n_ready=0, busy=1. The counter decrements each cycle. When counter==1, go to IDLE next cycle.
- Latency:
  - Transfer at edge t gives LOAD outputs visible after edge t+1.
  - n_ready returns high N+SETTLE_EXTRA+1 cycles after LOAD.
- p_odd, p_even and sel_odd change only in LOAD or reset. They are otherwise stable, so the downstream change-detect never fires spuriously.
- n_valid while n_ready=0 is ignored; no queuing. The requester must hold n_valid until it sees n_ready.
- A request for the ratio already in effect is still processed fully: it produces a reload and a div_reset pulse.
- Reset mid-LOAD or mid-SETTLE aborts to the reset values. Any latched N is discarded.
- cfg_err and a valid transfer cannot coincide, since there is one request per cycle.
- n_ready is a registered output; it is not combinational from n_valid.

Test Plan:
- Reset then idle: reset 2 cycles -> p_odd=3, sel_odd=1, p_even=1, div_reset high during reset only, n_ready=1 from the first cycle after reset.
- Odd load: n_in=7 with n_valid for 1 cycle -> next cycle p_odd=7, sel_odd=1, div_reset=1 for exactly 1 cycle; n_ready low for 1+7+2=10 cycles, then high.
- Even load: n_in=10 -> p_even=5, sel_odd=0, p_odd keeps its prior value; n_ready returns after 13 cycles.
- Reject: n_in=1, then n_in=0 -> cfg_err pulses once per request, outputs unchanged, no div_reset, n_ready stays 1.
- Busy ignore: n_in=9 accepted, then n_in=4 offered during SETTLE -> ignored; held n_valid is accepted on the first n_ready=1 cycle, giving p_even=2.
- Max and abort: n_in=255 (SIZE=8) -> settle count 257 with no wrap; assert reset at settle cycle 100 -> reset values restored, n_ready=1 the cycle after reset falls.

Source files
------------

// File: rtl/div_ratio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_ratio_ctrl
// Brief    : Range-checks a requested division ratio, loads the odd or even
//            divider's P value, pulses the divider reset and holds off new
//            requests while the divider output settles.
// Revision : 1.0
// ============================================================================
module div_ratio_ctrl #(
    parameter int SIZE         = 8,
    parameter int DEFAULT_N    = 3,
    parameter int SETTLE_EXTRA = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE-1:0] n_in,
    input  logic            n_valid,
    output logic            n_ready,
    output logic [SIZE-1:0] p_odd,
    output logic [SIZE-1:0] p_even,
    output logic            sel_odd,
    output logic            div_reset,
    output logic            cfg_err,
    output logic            busy
);

    localparam int              CW          = SIZE + 1;
    localparam logic [SIZE-1:0] RESET_P_ODD = SIZE'(DEFAULT_N);
    localparam logic [CW-1:0]   EXTRA       = CW'(SETTLE_EXTRA);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [SIZE-1:0] n_lat, n_lat_nx;
    logic [SIZE-1:0] p_odd_nx, p_even_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            ready_nx, sel_nx, dreset_nx, err_nx;
    logic            xfer, n_ok;

    assign xfer = n_valid && n_ready;
    // Ratios 0 and 1 are the only ones with no bit set above bit 0.
    assign n_ok = |n_in[SIZE-1:1];
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            n_lat     <= '0;
            cnt       <= '0;
            n_ready   <= 1'b0;
            p_odd     <= RESET_P_ODD;
            p_even    <= SIZE'(1);
            sel_odd   <= 1'b1;
            div_reset <= 1'b1;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            n_lat     <= n_lat_nx;
            cnt       <= cnt_nx;
            n_ready   <= ready_nx;
            p_odd     <= p_odd_nx;
            p_even    <= p_even_nx;
            sel_odd   <= sel_nx;
            div_reset <= dreset_nx;
            cfg_err   <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        n_lat_nx  = n_lat;
        cnt_nx    = cnt;
        p_odd_nx  = p_odd;
        p_even_nx = p_even;
        sel_nx    = sel_odd;
        ready_nx  = 1'b0;
        dreset_nx = 1'b0;
        err_nx    = 1'b0;
        case (state)
            S_IDLE: begin
                ready_nx = 1'b1;
                if (xfer) begin
                    if (n_ok) begin
                        n_lat_nx = n_in;
                        state_nx = S_LOAD;
                        ready_nx = 1'b0;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                dreset_nx = 1'b1;
                if (n_lat[0]) begin
                    p_odd_nx = n_lat;
                    sel_nx   = 1'b1;
                end else begin
                    p_even_nx = n_lat >> 1;
                    sel_nx    = 1'b0;
                end
                // One extra bit keeps N + SETTLE_EXTRA from wrapping at the top ratio.
                cnt_nx   = {1'b0, n_lat} + EXTRA;
                state_nx = S_SETTLE;
            end
            S_SETTLE: begin
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nx = S_IDLE;
                    ready_nx = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_div_ratio_ctrl.sv
`default_nettype none
// Testbench for div_ratio_ctrl: directed scenarios plus randomized ratios
// checked against a ratio-level model of the control stage.
module tb_div_ratio_ctrl;
    localparam int SIZE         = 8;
    localparam int DEFAULT_N    = 3;
    localparam int SETTLE_EXTRA = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            n_valid = 1'b0;
    logic [SIZE-1:0] n_in = '0;
    logic            n_ready, sel_odd, div_reset, cfg_err, busy;
    logic [SIZE-1:0] p_odd, p_even;

    int checks = 0;
    int errors = 0;

    logic [SIZE-1:0] m_p_odd, m_p_even;
    logic            m_sel;

    div_ratio_ctrl #(.SIZE(SIZE), .DEFAULT_N(DEFAULT_N), .SETTLE_EXTRA(SETTLE_EXTRA)) dut (
        .clk(clk), .reset(reset), .n_in(n_in), .n_valid(n_valid), .n_ready(n_ready),
        .p_odd(p_odd), .p_even(p_even), .sel_odd(sel_odd), .div_reset(div_reset),
        .cfg_err(cfg_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_p_odd  = SIZE'(DEFAULT_N);
        m_p_even = SIZE'(1);
        m_sel    = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; n_valid = 1'b0;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (n_ready !== 1'b0 || div_reset !== 1'b1 || cfg_err !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl: n_ready=%b div_reset=%b cfg_err=%b busy=%b, required 0 1 0 0",
                         n_ready, div_reset, cfg_err, busy);
            end
            checks++;
            if (p_odd !== m_p_odd || p_even !== m_p_even || sel_odd !== m_sel) begin
                errors++;
                $display("FAIL reset_cfg: p_odd=%0d p_even=%0d sel_odd=%b, required %0d %0d %b",
                         p_odd, p_even, sel_odd, m_p_odd, m_p_even, m_sel);
            end
        end
        reset = 1'b0;
        tick();
        checks++;
        if (n_ready !== 1'b1 || div_reset !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: n_ready=%b div_reset=%b busy=%b, required 1 0 0",
                     n_ready, div_reset, busy);
        end
    endtask

    // Full accepted-request sequence for a valid ratio n, checked against the model.
    task automatic test_load(input int n);
        int low, pulses;
        bit stable, first_dr;
        n_in = SIZE'(n); n_valid = 1'b1;
        tick();
        n_valid = 1'b0; n_in = SIZE'($urandom);
        checks++;
        if (n_ready !== 1'b0 || busy !== 1'b1 || div_reset !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL load%0d_accept: n_ready=%b busy=%b div_reset=%b cfg_err=%b, required 0 1 0 0",
                     n, n_ready, busy, div_reset, cfg_err);
        end
        checks++;
        if (p_odd !== m_p_odd || p_even !== m_p_even || sel_odd !== m_sel) begin
            errors++;
            $display("FAIL load%0d_early: p_odd=%0d p_even=%0d sel=%b, required unchanged %0d %0d %b",
                     n, p_odd, p_even, sel_odd, m_p_odd, m_p_even, m_sel);
        end
        if (n % 2 == 1) begin m_p_odd = SIZE'(n); m_sel = 1'b1; end
        else begin m_p_even = SIZE'(n / 2); m_sel = 1'b0; end
        low = 1; pulses = 0; stable = 1'b1; first_dr = 1'b0;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (div_reset === 1'b1) pulses++;
            if (k == 0) first_dr = (div_reset === 1'b1);
            if (p_odd !== m_p_odd || p_even !== m_p_even || sel_odd !== m_sel) stable = 1'b0;
            if (n_ready === 1'b1) break;
            low++;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL load%0d_cfg: p_odd=%0d p_even=%0d sel=%b, required %0d %0d %b throughout",
                     n, p_odd, p_even, sel_odd, m_p_odd, m_p_even, m_sel);
        end
        checks++;
        if (pulses != 1 || !first_dr) begin
            errors++;
            $display("FAIL load%0d_divreset: pulses=%0d first=%b, required 1 1", n, pulses, first_dr);
        end
        checks++;
        if (low != n + SETTLE_EXTRA + 1) begin
            errors++;
            $display("FAIL load%0d_holdoff: n_ready low %0d cycles, required %0d", n, low, n + SETTLE_EXTRA + 1);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL load%0d_busy_end: busy=%b, required 0", n, busy);
        end
    endtask

    task automatic test_reject;
        int bad[2] = '{1, 0};
        foreach (bad[i]) begin
            n_in = SIZE'(bad[i]); n_valid = 1'b1;
            tick();
            n_valid = 1'b0;
            checks++;
            if (cfg_err !== 1'b1 || n_ready !== 1'b1 || div_reset !== 1'b0 || busy !== 1'b0 ||
                p_odd !== m_p_odd || p_even !== m_p_even || sel_odd !== m_sel) begin
                errors++;
                $display("FAIL reject%0d: cfg_err=%b n_ready=%b div_reset=%b busy=%b p_odd=%0d p_even=%0d sel=%b, required 1 1 0 0 %0d %0d %b",
                         bad[i], cfg_err, n_ready, div_reset, busy, p_odd, p_even, sel_odd, m_p_odd, m_p_even, m_sel);
            end
            tick();
            checks++;
            if (cfg_err !== 1'b0 || n_ready !== 1'b1 || div_reset !== 1'b0) begin
                errors++;
                $display("FAIL reject%0d_after: cfg_err=%b n_ready=%b div_reset=%b, required 0 1 0",
                         bad[i], cfg_err, n_ready, div_reset);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int low;
        bit stable;
        n_in = SIZE'(9); n_valid = 1'b1;
        tick();
        n_in = SIZE'(4);
        m_p_odd = SIZE'(9); m_sel = 1'b1;
        low = 1; stable = 1'b1;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (p_odd !== m_p_odd || p_even !== m_p_even || sel_odd !== m_sel) stable = 1'b0;
            if (n_ready === 1'b1) break;
            low++;
        end
        checks++;
        if (!stable || low != 9 + SETTLE_EXTRA + 1) begin
            errors++;
            $display("FAIL busy_ignore: stable=%b low=%0d p_even=%0d, required 1 %0d %0d",
                     stable, low, p_even, 9 + SETTLE_EXTRA + 1, m_p_even);
        end
        tick();
        n_valid = 1'b0;
        checks++;
        if (n_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_held_accept: n_ready=%b busy=%b, required 0 1", n_ready, busy);
        end
        m_p_even = SIZE'(2); m_sel = 1'b0;
        tick();
        checks++;
        if (p_even !== m_p_even || sel_odd !== m_sel || p_odd !== m_p_odd || div_reset !== 1'b1) begin
            errors++;
            $display("FAIL busy_held_load: p_even=%0d sel=%b p_odd=%0d div_reset=%b, required 2 0 9 1",
                     p_even, sel_odd, p_odd, div_reset);
        end
        low = 2;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (n_ready === 1'b1) break;
            low++;
        end
        checks++;
        if (low != 4 + SETTLE_EXTRA + 1) begin
            errors++;
            $display("FAIL busy_held_holdoff: n_ready low %0d cycles, required %0d", low, 4 + SETTLE_EXTRA + 1);
        end
    endtask

    task automatic test_max_abort;
        bit stayed;
        n_in = SIZE'(255); n_valid = 1'b1;
        tick();
        n_valid = 1'b0;
        tick();
        checks++;
        if (p_odd !== 8'd255 || sel_odd !== 1'b1 || div_reset !== 1'b1) begin
            errors++;
            $display("FAIL max_load: p_odd=%0d sel=%b div_reset=%b, required 255 1 1", p_odd, sel_odd, div_reset);
        end
        stayed = 1'b1;
        for (int k = 2; k <= 100; k++) begin
            tick();
            if (n_ready !== 1'b0 || busy !== 1'b1) stayed = 1'b0;
        end
        checks++;
        if (!stayed) begin
            errors++;
            $display("FAIL max_nowrap: n_ready=%b busy=%b during settle, required 0 1", n_ready, busy);
        end
        reset = 1'b1;
        model_reset();
        tick();
        checks++;
        if (n_ready !== 1'b0 || div_reset !== 1'b1 || busy !== 1'b0 || cfg_err !== 1'b0 ||
            p_odd !== m_p_odd || p_even !== m_p_even || sel_odd !== m_sel) begin
            errors++;
            $display("FAIL abort_reset: n_ready=%b div_reset=%b busy=%b cfg_err=%b p_odd=%0d p_even=%0d sel=%b, required 0 1 0 0 %0d %0d %b",
                     n_ready, div_reset, busy, cfg_err, p_odd, p_even, sel_odd, m_p_odd, m_p_even, m_sel);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (n_ready !== 1'b1 || div_reset !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_release: n_ready=%b div_reset=%b busy=%b, required 1 0 0", n_ready, div_reset, busy);
        end
    endtask

    task automatic test_random;
        int n;
        for (int it = 0; it < 24; it++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
            if ($urandom_range(0, 5) == 0) n = $urandom_range(0, 1);
            else n = $urandom_range(2, (1 << SIZE) - 1);
            if (n < 2) begin
                n_in = SIZE'(n); n_valid = 1'b1;
                tick();
                n_valid = 1'b0;
                checks++;
                if (cfg_err !== 1'b1 || n_ready !== 1'b1 || div_reset !== 1'b0 ||
                    p_odd !== m_p_odd || p_even !== m_p_even || sel_odd !== m_sel) begin
                    errors++;
                    $display("FAIL rand_reject%0d: cfg_err=%b n_ready=%b div_reset=%b p_odd=%0d p_even=%0d sel=%b, required 1 1 0 %0d %0d %b",
                             n, cfg_err, n_ready, div_reset, p_odd, p_even, sel_odd, m_p_odd, m_p_even, m_sel);
                end
            end else begin
                test_load(n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load(7);
        test_load(10);
        test_load(10);
        test_reject();
        test_busy_ignore();
        test_max_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
